// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the unified memory port arbiter: FSM state encoding,
//   transaction owner, and the latched request record that drives the
//   registered m_* outputs.
package mem_arb_pkg;

  // Widths of the latched request record; the arbiter is elaborated with
  // matching AW/DW values.
  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;
  localparam int REQ_BW = REQ_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [REQ_BW-1:0] be;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
  } req_t;

  // A fetch is always a full-width read.
  function automatic req_t fetch_req(input logic [REQ_AW-1:0] addr);
    req_t r;
    r.we    = 1'b0;
    r.be    = '1;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch side (I) and the
//   load/store side (D) of the core. One transaction is outstanding at a
//   time. D has fixed priority, but after STREAK_MAX consecutive D grants
//   taken while a fetch was waiting, the fetch is forced through.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   i_req/i_addr         fetch request, held until i_gnt
//   i_gnt                one-cycle accept pulse (combinational)
//   i_rvalid/i_rdata     fetch response (combinational from m_rvalid)
//   d_req/d_we/d_be/     load/store request, held until d_gnt
//   d_addr/d_wdata
//   d_gnt                one-cycle accept pulse (combinational)
//   d_rvalid/d_rdata     load data / store acknowledge
//   m_req/m_we/m_be/     registered request to memory, stable until m_gnt
//   m_addr/m_wdata
//   m_gnt                memory accepted the request
//   m_rvalid/m_rdata     memory response (read data or write ack)
//   busy                 a transaction is in flight (state != IDLE)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = REQ_AW,
  parameter int DW         = REQ_DW,
  parameter int STREAK_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  // instruction fetch side
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  // load/store side
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // memory side
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  // status
  output logic            busy
);

  // Wide enough to hold the value STREAK_MAX itself.
  localparam int STREAK_W = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

  // Elaboration-time guards: the request record is sized by the package.
  if (AW != REQ_AW || DW != REQ_DW) begin : g_width_check
    $error("mem_port_arbiter: AW/DW must match mem_arb_pkg REQ_AW/REQ_DW");
  end
  if (STREAK_MAX < 1) begin : g_streak_check
    $error("mem_port_arbiter: STREAK_MAX must be at least 1");
  end

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  state_t              state_reg,  state_next;
  owner_t              owner_reg,  owner_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  req_t                req_reg,    req_next;
  logic                m_req_reg,  m_req_next;

  // --------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------
  logic arb_point;
  logic streak_full;
  logic pick_d;
  logic pick_i;
  logic rsp;

  always_comb begin
    // Grants are decided in IDLE or in the response cycle of WAIT; the
    // reset term keeps every combinational output quiet while reset is
    // held, even though the state register already reads IDLE.
    arb_point   = !reset && ((state_reg == IDLE) ||
                             ((state_reg == WAIT) && m_rvalid));
    streak_full = (streak_reg == STREAK_W'(STREAK_MAX));
    pick_d      = arb_point && d_req && !(i_req && streak_full);
    pick_i      = arb_point && i_req && !pick_d;
    // m_rvalid outside WAIT (IDLE or ADDR) is a stray pulse and dropped.
    rsp         = !reset && (state_reg == WAIT) && m_rvalid;
  end

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    streak_next = streak_reg;
    req_next    = req_reg;
    m_req_next  = m_req_reg;

    if (pick_d) begin
      req_next.we    = d_we;
      req_next.be    = d_be;
      req_next.addr  = d_addr;
      req_next.wdata = d_wdata;
      owner_next     = OWN_D;
      state_next     = ADDR;
      m_req_next     = 1'b1;
      // Only D grants that overtake a waiting fetch count toward the
      // starvation limit; the count saturates at STREAK_MAX.
      if (i_req) begin
        streak_next = streak_full ? streak_reg : streak_reg + STREAK_W'(1);
      end else begin
        streak_next = '0;
      end
    end else if (pick_i) begin
      req_next    = fetch_req(i_addr);
      owner_next  = OWN_I;
      state_next  = ADDR;
      m_req_next  = 1'b1;
      streak_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end
        ADDR: begin
          if (m_gnt) begin
            state_next = WAIT;
            m_req_next = 1'b0;
          end
        end
        WAIT: begin
          // Response with nobody waiting: the port goes idle.
          if (m_rvalid) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          m_req_next = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_I;
      streak_reg <= '0;
      req_reg    <= '0;
      m_req_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      streak_reg <= streak_next;
      req_reg    <= req_next;
      m_req_reg  <= m_req_next;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign i_gnt    = pick_i;
  assign d_gnt    = pick_d;

  assign i_rvalid = rsp && (owner_reg == OWN_I);
  assign d_rvalid = rsp && (owner_reg == OWN_D);
  // The non-owner sees zero data rather than the shared bus.
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  assign m_req    = m_req_reg;
  assign m_we     = req_reg.we;
  assign m_be     = req_reg.be;
  assign m_addr   = req_reg.addr;
  assign m_wdata  = req_reg.wdata;

  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (STREAK_MAX=2). A table of
//   single transactions is run first, then hand-written back-to-back and
//   reset-in-flight sequences. Expected responses go into a scoreboard
//   queue at grant time and are popped when the response cycle is reached.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          i_req;
    logic [31:0]   i_addr;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    int            gnt_wait;
    int            rsp_wait;
    logic [31:0]   rdata;
    logic          exp_d;
  } vec_t;

  typedef struct {
    logic          is_d;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
  } sb_t;

  sb_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  // Grant/response exclusivity, checked on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid)) begin
        n_fail++;
        $display("FAIL exclusive: gnt=%b%b rvalid=%b%b required at most one each",
                 i_gnt, d_gnt, i_rvalid, d_rvalid);
      end
    end
  end

  function automatic sb_t expect_of(input vec_t v);
    sb_t e;
    e.is_d  = v.exp_d;
    e.rdata = v.rdata;
    if (v.exp_d) begin
      e.we = v.d_we; e.be = v.d_be; e.addr = v.d_addr; e.wdata = v.d_wdata;
    end else begin
      e.we = 1'b0; e.be = 4'hF; e.addr = v.i_addr; e.wdata = 32'h0;
    end
    return e;
  endfunction

  task automatic chk_mfields(input string tag, input sb_t e);
    chk({tag, "_m_req"},   m_req,   1'b1);
    chk({tag, "_m_we"},    m_we,    e.we);
    chk({tag, "_m_be"},    m_be,    e.be);
    chk({tag, "_m_addr"},  m_addr,  e.addr);
    chk({tag, "_m_wdata"}, m_wdata, e.wdata);
  endtask

  task automatic chk_no_rsp(input string tag);
    chk({tag, "_i_rvalid"}, i_rvalid, 1'b0);
    chk({tag, "_d_rvalid"}, d_rvalid, 1'b0);
  endtask

  // Called in a cycle where the DUT should present a response.
  task automatic chk_rsp(input string tag);
    sb_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb_empty: actual=response required=no pending entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_i_rvalid"}, i_rvalid, !e.is_d);
    chk({tag, "_d_rvalid"}, d_rvalid, e.is_d);
    chk({tag, "_i_rdata"},  i_rdata,  e.is_d ? 32'h0 : e.rdata);
    chk({tag, "_d_rdata"},  d_rdata,  e.is_d ? e.rdata : 32'h0);
  endtask

  // One complete transaction from IDLE back to IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    sb_t e;
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_be = v.d_be;
    d_addr = v.d_addr; d_wdata = v.d_wdata;
    settle();
    chk({tag, "_i_gnt"}, i_gnt, !v.exp_d);
    chk({tag, "_d_gnt"}, d_gnt, v.exp_d);
    e = expect_of(v);
    sb_q.push_back(e);
    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    // ADDR: stray m_rvalid while stalled must be ignored.
    for (int k = 0; k <= v.gnt_wait; k++) begin
      m_gnt    = (k == v.gnt_wait);
      m_rvalid = (k != v.gnt_wait);
      m_rdata  = 32'hBAD0_0000 | k;
      settle();
      chk_mfields($sformatf("%s_addr%0d", tag, k), e);
      chk_no_rsp($sformatf("%s_addr%0d", tag, k));
      chk($sformatf("%s_addr%0d_busy", tag, k), busy, 1'b1);
      next_cycle();
    end
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    for (int k = 0; k < v.rsp_wait; k++) begin
      settle();
      chk($sformatf("%s_wait%0d_m_req", tag, k), m_req, 1'b0);
      chk_no_rsp($sformatf("%s_wait%0d", tag, k));
      next_cycle();
    end
    m_rvalid = 1'b1; m_rdata = v.rdata;
    settle();
    chk_rsp({tag, "_rsp"});
    chk({tag, "_rsp_m_req"}, m_req, 1'b0);
    next_cycle();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    settle();
    chk({tag, "_done_busy"}, busy, 1'b0);
    $display("txn %s: owner=%s addr=0x%08h rdata=0x%08h", tag,
             v.exp_d ? "D" : "I", e.addr, v.rdata);
    next_cycle();
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic we, input logic [3:0] be, input logic [31:0] da,
                              input logic [31:0] wd, input int gw, input int rw,
                              input logic [31:0] rd, input logic ed);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = we; v.d_be = be;
    v.d_addr = da; v.d_wdata = wd; v.gnt_wait = gw; v.rsp_wait = rw;
    v.rdata = rd; v.exp_d = ed;
    return v;
  endfunction

  vec_t vecs[10];
  vec_t v;
  sb_t  e;

  initial begin
    // Grant order with both requesting (STREAK_MAX=2): D, D, I, D, D, I.
    vecs[0] = mk(1, 32'h0000_0100, 0, 0, 4'h0, 32'h0,         32'h0,         0, 1, 32'h0050_0093, 0);
    vecs[1] = mk(0, 32'h0,         1, 1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF, 3, 0, 32'h0000_0000, 1);
    vecs[2] = mk(0, 32'h0,         1, 0, 4'hF, 32'h0000_3004, 32'h0,         1, 2, 32'h1234_5678, 1);
    vecs[3] = mk(1, 32'h0000_0200, 1, 0, 4'hF, 32'h0000_4000, 32'h0,         0, 0, 32'hA000_0001, 1);
    vecs[4] = mk(1, 32'h0000_0200, 1, 1, 4'hC, 32'h0000_4004, 32'h5555_AAAA, 0, 0, 32'hA000_0002, 1);
    vecs[5] = mk(1, 32'h0000_0200, 1, 0, 4'hF, 32'h0000_4008, 32'h0,         0, 0, 32'hA000_0003, 0);
    vecs[6] = mk(1, 32'h0000_0204, 1, 0, 4'h1, 32'h0000_4008, 32'h0,         1, 0, 32'hA000_0004, 1);
    vecs[7] = mk(1, 32'h0000_0204, 1, 0, 4'hF, 32'h0000_400C, 32'h0,         0, 1, 32'hA000_0005, 1);
    vecs[8] = mk(1, 32'h0000_0204, 1, 0, 4'hF, 32'h0000_4010, 32'h0,         0, 0, 32'hA000_0006, 0);
    vecs[9] = mk(0, 32'h0,         1, 0, 4'hF, 32'h0000_5000, 32'h0,         0, 0, 32'hA000_0007, 1);

    // Reset with both requests high: nothing may be granted.
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0;
    #3;
    chk("rst_i_gnt", i_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk_no_rsp("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;
    settle();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_m_req", m_req, 1'b0);
    next_cycle();

    for (int n = 0; n < 10; n++) begin
      run_vec(vecs[n], $sformatf("v%0d", n));
    end

    // Back-to-back: D request pending when the fetch response returns.
    i_req = 1'b1; i_addr = 32'h0000_0400;
    settle();
    chk("b2b_i_gnt", i_gnt, 1'b1);
    v = mk(1, 32'h0000_0400, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h1111_2222, 0);
    sb_q.push_back(expect_of(v));
    next_cycle();
    i_req = 1'b0; m_gnt = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_6000; d_wdata = 32'h0;
    settle();
    chk("b2b_addr_d_gnt", d_gnt, 1'b0);
    next_cycle();
    m_gnt = 1'b0;
    settle();
    chk("b2b_wait_d_gnt", d_gnt, 1'b0);
    chk("b2b_wait_m_req", m_req, 1'b0);
    next_cycle();
    m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
    settle();
    chk_rsp("b2b_i_rsp");
    chk("b2b_rsp_d_gnt", d_gnt, 1'b1);
    v = mk(0, 32'h0, 1, 0, 4'hF, 32'h0000_6000, 32'h0, 0, 0, 32'h3333_4444, 1);
    e = expect_of(v);
    sb_q.push_back(e);
    $display("txn b2b_i: owner=I addr=0x00000400 rdata=0x11112222");
    next_cycle();
    d_req = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_gnt = 1'b1;
    settle();
    chk_mfields("b2b_d", e);
    chk("b2b_d_busy", busy, 1'b1);
    next_cycle();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h3333_4444;
    settle();
    chk_rsp("b2b_d_rsp");
    $display("txn b2b_d: owner=D addr=0x00006000 rdata=0x33334444");
    next_cycle();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    settle();
    chk("b2b_done_busy", busy, 1'b0);
    next_cycle();

    // Reset mid-transaction with the streak at its limit.
    run_vec(mk(1, 32'h0000_0800, 1, 0, 4'hF, 32'h0000_7000, 32'h0, 0, 0, 32'hC000_0001, 1), "rs0");
    i_req = 1'b1; i_addr = 32'h0000_0800;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0000_7004; d_wdata = 32'h0BAD_F00D;
    settle();
    chk("rs1_d_gnt", d_gnt, 1'b1);
    next_cycle();
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b1;
    next_cycle();
    m_gnt = 1'b0; i_req = 1'b1; d_req = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_0000;
    #1;
    reset = 1'b1;
    #3;
    chk("rs_mid_m_req", m_req, 1'b0);
    chk("rs_mid_busy", busy, 1'b0);
    chk("rs_mid_i_gnt", i_gnt, 1'b0);
    chk("rs_mid_d_gnt", d_gnt, 1'b0);
    chk_no_rsp("rs_mid");
    next_cycle();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    settle();
    chk("rs_stale_busy", busy, 1'b0);
    chk("rs_stale_m_req", m_req, 1'b0);
    chk_no_rsp("rs_stale");
    next_cycle();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    // Streak was cleared by reset, so D wins again over a waiting fetch.
    run_vec(mk(1, 32'h0000_0900, 1, 0, 4'hF, 32'h0000_7008, 32'h0, 0, 0, 32'hC000_0002, 1), "rs2");

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between two requesters of the pipelined RV32I core: instruction fetch (I-side, from the IF stage) and load/store (D-side, from the MEM stage).
- Single outstanding transaction, registered request issue, fixed D-priority with anti-starvation streak limit.
- Sits between the core's fetch/MEM stages and the external memory; the hazard logic uses busy/gnt/rvalid to generate stalls.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8)
- STREAK_MAX, 4, maximum consecutive D grants while i_req is pending before I is forced (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held with i_addr until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  one-cycle pulse: fetch request accepted
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DW  fetch data
- d_req  in  1  load/store request, held with fields until d_gnt
- d_we  in  1  1 = store
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle pulse: D request accepted
- d_rvalid  out  1  load data / store ack valid
- d_rdata  out  DW  load data
- m_req  out  1  memory request (registered)
- m_we  out  1  memory write (registered)
- m_be  out  DW/8  memory byte enables (registered)
- m_addr  out  AW  memory address (registered)
- m_wdata  out  DW  memory write data (registered)
- m_gnt  in  1  memory accepted request
- m_rvalid  in  1  memory response (read data or write ack)
- m_rdata  in  DW  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, owner=I, streak=0, every output 0. Reset mid-transaction aborts it with no response to either side; m_req drops immediately.
- The design has one clock, clk, and one reset, reset, which is asynchronous and active-high.
- FSM states are IDLE, ADDR and WAIT.
- An arbitration point is IDLE, or WAIT with m_rvalid=1.
  - If any req is high: pick the winner, pulse its gnt combinationally in that cycle, latch its fields into the m_* registers, set m_req=1 and go to ADDR next cycle.
  - For an I grant: m_we=0, m_be all ones, m_wdata=0.
  - With no req: go to (or stay in) IDLE.
- ADDR: hold m_req and the m_* fields stable until m_gnt=1. Then go to WAIT next cycle with m_req=0. m_rvalid is ignored in ADDR.
- WAIT: when m_rvalid=1, the owner's x_rvalid=1 combinationally and x_rdata=m_rdata. The non-owner's rvalid=0 and rdata=0. Stores also complete on m_rvalid.
- Back-to-back: a WAIT-with-m_rvalid cycle that has a pending req goes straight to ADDR, with no IDLE bubble.
- m_rvalid in IDLE is ignored.
- Minimum latency: req at cycle 0 (gnt) → m_req at cycle 1 → m_gnt at cycle 1 → WAIT at cycle 2 → earliest rvalid at cycle 2.
- Arbitration rules:
  - Only i_req: I wins. Only d_req: D wins.
  - Both high: D wins unless streak==STREAK_MAX, in which case I wins.
- streak rules, applied at each grant:
  - D granted while i_req=1: streak+1, saturating at STREAK_MAX.
  - I granted, or D granted with i_req=0: streak=0.
- Requesters may drop req the cycle after gnt. req dropped before gnt is legal; nothing is issued.
- gnt never asserts in ADDR, or in WAIT without m_rvalid.
- At most one of i_gnt/d_gnt, and at most one of i_rvalid/d_rvalid, is high in any cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum state_t {IDLE, ADDR, WAIT}
  - typedef enum owner_t {OWN_I, OWN_D}
  - a req_t struct {we, be, addr, wdata} used for the latched request
- No sub-module: FSM, arbiter and streak counter fit in one module.

Test Plan:
- Single fetch:
  - i_req=1, i_addr=0x0000_0100 at cycle 0 → i_gnt pulse at cycle 0; m_req=1, m_addr=0x100, m_we=0 at cycle 1.
  - m_gnt at cycle 1, m_rvalid with m_rdata=0x00500093 at cycle 3 → i_rvalid=1, i_rdata=0x00500093 at cycle 3; busy=0 at cycle 4.
- Store with stalled memory:
  - d_req, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF.
  - m_gnt held low 3 cycles → m_* stay stable through all ADDR cycles.
  - m_rvalid → d_rvalid=1 and i_rvalid=0.
- Simultaneous requests, STREAK_MAX=2:
  - i_req held high while d_req is re-asserted after each d_gnt → grant order D, D, I, D, D, I.
  - streak returns to 0 after each I grant.
- Back-to-back:
  - d_req pending when m_rvalid returns for an I transaction → d_gnt in the same cycle as i_rvalid, and m_req=1 the next cycle with no IDLE cycle.
- Reset mid-operation:
  - assert reset in WAIT → m_req, busy, all gnt/rvalid 0 immediately; state=IDLE, streak=0.
  - A stale m_rvalid after reset release produces no i_rvalid or d_rvalid.
- Spurious response:
  - m_rvalid=1 in IDLE and in ADDR → no rvalid output; ADDR holds until m_gnt.
